// File: rtl/kmq_pkg.sv
// Shared encodings for the keypad-to-maze-move command path.
package kmq_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE    = 3'd0,
    CMD_UP      = 3'd1,
    CMD_DOWN    = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_RIGHT   = 3'd4,
    CMD_SELECT  = 3'd5,
    CMD_RESTART = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  // Keypad codes as reported by the Key44 scanner
  localparam logic [3:0] KEY_UP      = 4'h2;
  localparam logic [3:0] KEY_DOWN    = 4'h8;
  localparam logic [3:0] KEY_LEFT    = 4'h4;
  localparam logic [3:0] KEY_RIGHT   = 4'h6;
  localparam logic [3:0] KEY_SELECT  = 4'h5;
  localparam logic [3:0] KEY_RESTART = 4'hF;

  // Row lines are active-low; all ones means no contact
  localparam logic [3:0] ROW_IDLE = 4'hF;

  // Map a keypad code to a move; unmapped keys give CMD_NONE
  function automatic cmd_e decode_key(input logic [3:0] code);
    cmd_e c;
    case (code)
      KEY_UP:      c = CMD_UP;
      KEY_DOWN:    c = CMD_DOWN;
      KEY_LEFT:    c = CMD_LEFT;
      KEY_RIGHT:   c = CMD_RIGHT;
      KEY_SELECT:  c = CMD_SELECT;
      KEY_RESTART: c = CMD_RESTART;
      default:     c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with valid/ready read side. A push while full is
// only accepted when a pop frees the head slot in the same cycle.
module cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              pop;
  logic              do_push;

  // Handshake decode, pointer/count next state and head presentation
  always_comb begin
    valid    = (count_q != '0);
    full     = (count_q == FULL_CNT);
    pop      = valid && ready;
    do_push  = push && (!full || pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && pop) begin
      count_d = count_q - CNT_ONE;
    end
    data = valid ? mem_q[rd_ptr_q] : '0;
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/key_move_queue.sv
// Debounces keypad presses from the Key44 scanner, maps them to maze moves
// and queues them for the game engine over a valid/ready handshake.
module key_move_queue
  import kmq_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int RELEASE_CYCLES = 64,
  parameter int REPEAT_CYCLES  = 0,
  parameter int DEPTH          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic [3:0] key_value,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       key_down,
  output logic       overflow
);

  localparam int CNT_MAX = (STABLE_CYCLES > REPEAT_CYCLES) ? STABLE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int ACT_W   = $clog2(RELEASE_CYCLES + 1);
  localparam bit REPEAT_EN = (REPEAT_CYCLES != 0);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_EN ? REPEAT_CYCLES - 1 : 0);
  localparam logic [ACT_W-1:0] ACT_ONE     = ACT_W'(1);
  localparam logic [ACT_W-1:0] ACT_RELOAD  = ACT_W'(RELEASE_CYCLES);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [ACT_W-1:0] act_q, act_d;
  state_e           state_q, state_d;
  logic [3:0]       kv_hold_q, kv_hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic             same_key;
  logic             stable_done;
  logic             repeat_due;
  logic             key_event;
  cmd_e             cmd_ev;
  logic             push;
  logic             fifo_full;
  logic [CMD_W-1:0] fifo_data;

  // Two-flop synchroniser on the raw row lines, then the release-hold counter
  always_comb begin
    sync1_d = row;
    sync2_d = sync1_q;
    if (sync2_q != ROW_IDLE) begin
      act_d = ACT_RELOAD;
    end else if (act_q != '0) begin
      act_d = act_q - ACT_ONE;
    end else begin
      act_d = act_q;
    end
  end

  assign key_down = (act_q != '0);

  // Shared press qualifiers used by both the next-state and output logic
  always_comb begin
    same_key    = (key_value == kv_hold_q);
    stable_done = key_down && same_key && (cnt_q == STABLE_LAST);
    repeat_due  = REPEAT_EN && key_down && same_key && (cnt_q == REPEAT_LAST);
  end

  // Press FSM next state: debounce a stable code, then track the hold
  always_comb begin
    state_d   = state_q;
    kv_hold_d = kv_hold_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (key_down) begin
          state_d   = ST_DEBOUNCE;
          kv_hold_d = key_value;
          cnt_d     = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!key_down) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same_key) begin
          kv_hold_d = key_value;
          cnt_d     = '0;
        end else if (stable_done) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!key_down) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same_key) begin
          // A different key while still held is a new press
          state_d   = ST_DEBOUNCE;
          kv_hold_d = key_value;
          cnt_d     = '0;
        end else if (REPEAT_EN) begin
          cnt_d = repeat_due ? '0 : (cnt_q + CNT_ONE);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Press FSM outputs: event strobe, decode, push and sticky drop flag
  always_comb begin
    key_event = 1'b0;
    case (state_q)
      ST_DEBOUNCE: key_event = stable_done;
      ST_HELD:     key_event = repeat_due;
      default:     key_event = 1'b0;
    endcase
    cmd_ev     = decode_key(kv_hold_q);
    push       = key_event && (cmd_ev != CMD_NONE);
    overflow_d = overflow_q || (push && fifo_full && !(cmd_valid && cmd_ready));
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= ROW_IDLE;
      sync2_q    <= ROW_IDLE;
      act_q      <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      act_q      <= act_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Held key code; only read once a press has latched it
  always_ff @(posedge clk) begin
    kv_hold_q <= kv_hold_d;
  end

  assign overflow = overflow_q;

  cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cmd_ev),
    .full      (fifo_full),
    .valid     (cmd_valid),
    .ready     (cmd_ready),
    .data      (fifo_data)
  );

  assign cmd = fifo_data;

endmodule

// File: tb/tb_key_move_queue.sv
// Directed and randomized bench for key_move_queue. Two instances: one with
// auto-repeat disabled, one with a 32-cycle repeat interval.
module tb_key_move_queue;

  localparam int STABLE  = 16;
  localparam int RELEASE = 64;
  localparam int REP_B   = 32;
  localparam int C_UP = 1, C_DOWN = 2, C_LEFT = 3, C_RIGHT = 4, C_SELECT = 5;
  // First push lands this many clocks after the row first goes low
  localparam int FIRST_PUSH = 2 + 1 + STABLE + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] kv;
  logic       ready_a, ready_b;
  logic [2:0] cmd_a, cmd_b;
  logic       cmd_valid_a, cmd_valid_b;
  logic       key_down_a, key_down_b;
  logic       overflow_a, overflow_b;

  int checks = 0;
  int errors = 0;
  int got_a[$];
  int got_b[$];
  int exp_q[$];
  bit rand_ready = 1'b0;
  // Keypad code -> command code table (0 = no command)
  int key_map [16] = '{0, 0, 1, 0, 3, 5, 4, 0, 2, 0, 0, 0, 0, 0, 0, 6};

  always #5 clk = ~clk;

  key_move_queue #(
    .STABLE_CYCLES(STABLE), .RELEASE_CYCLES(RELEASE), .REPEAT_CYCLES(0), .DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .row(row), .key_value(kv), .cmd(cmd_a),
    .cmd_valid(cmd_valid_a), .cmd_ready(ready_a), .key_down(key_down_a), .overflow(overflow_a)
  );

  key_move_queue #(
    .STABLE_CYCLES(STABLE), .RELEASE_CYCLES(RELEASE), .REPEAT_CYCLES(REP_B), .DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .row(row), .key_value(kv), .cmd(cmd_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(ready_b), .key_down(key_down_b), .overflow(overflow_b)
  );

  // Record every accepted transfer, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid_a && ready_a) got_a.push_back(int'(cmd_a));
      if (cmd_valid_b && ready_b) got_b.push_back(int'(cmd_b));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_ready) ready_a = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] key, input int hold, input logic [3:0] rowv);
    row = rowv;
    kv  = key;
    step(hold);
    row = 4'hF;
    step(RELEASE + 20);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    int rise;
    int rel;
    bit seen;
    int key;
    int hold;
    int rowv;

    reset = 1'b1; row = 4'hF; kv = 4'h0; ready_a = 1'b1; ready_b = 1'b1;
    step(3);
    reset = 1'b0;
    chk("reset_cmd_valid", cmd_valid_a, 0);
    chk("reset_cmd", cmd_a, 0);
    chk("reset_key_down", key_down_a, 0);
    chk("reset_overflow", overflow_a, 0);

    // Single press of key 2, with first-command latency
    got_a.delete();
    row = 4'b1110; kv = 4'h2; rise = -1;
    for (int k = 1; k <= 200; k++) begin
      step(1);
      if (cmd_valid_a && rise < 0) rise = k;
    end
    row = 4'hF;
    step(RELEASE + 20);
    chk("t1_latency", rise, FIRST_PUSH);
    chk("t1_count", got_a.size(), 1);
    chk("t1_cmd", got_a.size() > 0 ? got_a[0] : -1, C_UP);

    // Bouncing key code settles on 6
    got_a.delete();
    row = 4'b1011;
    for (int i = 0; i < 12; i++) begin
      kv = (i % 2 == 0) ? 4'h6 : 4'h4;
      step(5);
    end
    kv = 4'h6;
    step(40);
    row = 4'hF;
    step(RELEASE + 20);
    chk("t2_count", got_a.size(), 1);
    chk("t2_cmd", got_a.size() > 0 ? got_a[0] : -1, C_RIGHT);

    // Unmapped key: no command, key_down follows release timing
    got_a.delete();
    row = 4'b1101; kv = 4'hA; seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (cmd_valid_a) seen = 1'b1;
    end
    chk("t3_key_down_held", key_down_a, 1);
    row = 4'hF; rel = -1;
    for (int k = 1; k <= RELEASE + 20; k++) begin
      step(1);
      if (cmd_valid_a) seen = 1'b1;
      if (!key_down_a && rel < 0) rel = k;
    end
    chk("t3_release_time", rel, RELEASE + 2);
    chk("t3_no_valid", seen, 0);
    chk("t3_no_cmd", got_a.size(), 0);

    // Five presses with the consumer stalled: fourth fills, fifth drops
    got_a.delete();
    ready_a = 1'b0;
    press(4'h2, 40, 4'b1110);
    press(4'h8, 40, 4'b0111);
    press(4'h4, 40, 4'b1101);
    press(4'h6, 40, 4'b1011);
    press(4'h5, 40, 4'b1101);
    chk("t4_overflow", overflow_a, 1);
    chk("t4_valid_stalled", cmd_valid_a, 1);
    chk("t4_head_stable", cmd_a, C_UP);
    chk("t4_no_pop", got_a.size(), 0);
    ready_a = 1'b1;
    step(10);
    exp_q = '{C_UP, C_DOWN, C_LEFT, C_RIGHT};
    chk("t4_drain_count", got_a.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_drain_%0d", i), i < got_a.size() ? got_a[i] : -1, exp_q[i]);
    chk("t4_overflow_sticky", overflow_a, 1);
    chk("t4_empty", cmd_valid_a, 0);

    // Random presses with a randomly stalling consumer
    do_reset();
    got_a.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      key  = int'($urandom_range(0, 15));
      hold = STABLE + 5 + int'($urandom_range(0, 30));
      rowv = int'($urandom_range(0, 14));
      if (key_map[key] != 0) exp_q.push_back(key_map[key]);
      press(4'(key), hold, 4'(rowv));
    end
    rand_ready = 1'b0;
    ready_a = 1'b1;
    step(10);
    chk("rand_count", got_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rand_cmd_%0d", i), i < got_a.size() ? got_a[i] : -1, exp_q[i]);
    chk("rand_no_overflow", overflow_a, 0);

    // Auto-repeat: held key 8 gives one initial plus periodic commands
    do_reset();
    got_b.delete();
    row = 4'b0111; kv = 4'h8;
    step(STABLE + 100);
    row = 4'hF; kv = 4'h0;
    step(RELEASE + 40);
    chk("t5_repeat_count", got_b.size(), 1 + (STABLE + 100 - FIRST_PUSH) / REP_B);
    for (int i = 0; i < got_b.size(); i++)
      chk($sformatf("t5_repeat_cmd_%0d", i), got_b[i], C_DOWN);
    chk("t5_key_down_released", key_down_b, 0);

    // Full FIFO, pop and push in the same cycle
    got_b.delete();
    ready_b = 1'b0;
    row = 4'b0111; kv = 4'h8;
    step(FIRST_PUSH + 4 * REP_B - 1);
    chk("t5_full_valid", cmd_valid_b, 1);
    chk("t5_full_no_overflow", overflow_b, 0);
    ready_b = 1'b1;
    step(1);
    ready_b = 1'b0;
    chk("t5_pushpop_overflow", overflow_b, 0);
    step(2);
    row = 4'hF; kv = 4'h0;
    step(RELEASE + 40);
    chk("t5_one_pop", got_b.size(), 1);
    chk("t5_overflow_after", overflow_b, 0);
    ready_b = 1'b1;
    step(10);
    chk("t5_drain_count", got_b.size(), 5);
    for (int i = 0; i < got_b.size(); i++)
      chk($sformatf("t5_drain_cmd_%0d", i), got_b[i], C_DOWN);

    // Reset mid-debounce with a non-empty FIFO and overflow set
    got_a.delete();
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) press(4'h2, 30, 4'b1110);
    chk("t6_pre_valid", cmd_valid_a, 1);
    chk("t6_pre_overflow", overflow_a, 1);
    row = 4'b1110; kv = 4'h8;
    step(10);
    reset = 1'b1;
    step(1);
    chk("t6_valid", cmd_valid_a, 0);
    chk("t6_key_down", key_down_a, 0);
    chk("t6_overflow", overflow_a, 0);
    chk("t6_cmd", cmd_a, 0);
    reset = 1'b0;
    row = 4'hF;
    ready_a = 1'b1;
    step(RELEASE + 20);
    chk("t6_no_cmd", got_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
